// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned MULT/DIV with HI/LO result registers.
// Latency: WIDTH+1 cycles from accepted start to the done pulse; results land in HI/LO on that edge.
// Backpressure: start is taken only in IDLE; start while busy is dropped, not queued. No output stall.
//
// Optional feature: define MULDIV_FLUSH_EN to add i_flush (abort the running operation, HI/LO kept).
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start, i_op, i_x, i_y  operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   i_wr_hi, i_wr_lo, i_wr_data  MTHI/MTLO writes, honoured only while idle
//   i_flush               abort (MULDIV_FLUSH_EN only)
//   o_busy, o_done, o_div_by_zero  status; done/div_by_zero are one-cycle pulses
//   o_hi, o_lo            result registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_wr_hi,
  input  logic             i_wr_lo,
  input  logic [WIDTH-1:0] i_wr_data,
`ifdef MULDIV_FLUSH_EN
  input  logic             i_flush,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;     // product / quotient must be negated
  logic               r_neg_r;     // remainder must be negated
  logic               r_y_zero;    // divide with zero divisor
  logic [WIDTH-1:0]   r_b;         // multiplicand for MULT, divisor for DIV
  logic [2*WIDTH-1:0] r_acc;       // product accumulator; low half doubles as quotient
  logic [WIDTH-1:0]   r_rem;       // partial remainder (always < divisor, fits WIDTH)
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dbz;

  logic w_busy, w_start, w_fix, w_flush;
  logic w_signed, w_div;
  logic [WIDTH-1:0] w_x_mag, w_y_mag;

  assign w_busy   = (r_state != S_IDLE);
  assign w_start  = (r_state == S_IDLE) && i_start;
  assign w_signed = ~i_op[0];
  assign w_div    = i_op[1];

  // Most-negative input negates to itself, which is the correct unsigned magnitude.
  assign w_x_mag = (w_signed && i_x[WIDTH-1]) ? -i_x : i_x;
  assign w_y_mag = (w_signed && i_y[WIDTH-1]) ? -i_y : i_y;

`ifdef MULDIV_FLUSH_EN
  assign w_flush = i_flush && w_busy;
`else
  assign w_flush = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fix       = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_CALC;   // flush ignored here, start wins
      S_CALC: begin
        if (w_flush)                         w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(WIDTH - 1))    w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
        w_fix       = ~w_flush;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- iteration datapath
  // Shift-add: conditionally add multiplicand into the upper half, then shift right.
  logic [WIDTH:0]       w_madd;
  logic [2*WIDTH-1:0]   w_mul_nxt;
  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

  // Restoring divide: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_quo_nxt;
  assign w_shift   = {r_rem, r_acc[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_b});
  // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice.
  assign w_diff    = w_shift[WIDTH-1:0] - r_b;
  assign w_quo_nxt = {r_acc[WIDTH-2:0], w_ge};

  // ---------------------------------------------------------------- sign fix-up
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_y_zero ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  // With a zero divisor the remainder holds |x|; restoring its sign yields x as sampled.
  assign w_rem  = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_y_zero <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= w_fix;
      r_dbz  <= w_fix && r_is_div && r_y_zero;

      if (w_start) begin
        r_cnt    <= '0;
        r_is_div <= w_div;
        r_neg_q  <= w_signed && (i_x[WIDTH-1] ^ i_y[WIDTH-1]);
        r_neg_r  <= w_signed && i_x[WIDTH-1];
        r_y_zero <= w_div && (i_y == '0);
        r_b      <= w_div ? w_y_mag : w_x_mag;
        r_acc    <= {{WIDTH{1'b0}}, (w_div ? w_x_mag : w_y_mag)};
        r_rem    <= '0;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_is_div) begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_acc <= {{WIDTH{1'b0}}, w_quo_nxt};
        end else begin
          r_acc <= w_mul_nxt;
        end
      end

      // Result write and MTHI/MTLO are exclusive: FIX is never IDLE.
      if (w_fix) begin
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end else if (r_state == S_IDLE) begin
        if (i_wr_hi) r_hi <= i_wr_data;
        if (i_wr_lo) r_lo <= i_wr_data;
      end
    end
  end

  assign o_busy        = w_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [1:0]    i_op = 2'b00;
  logic [W-1:0]  i_x = '0, i_y = '0;
  logic          i_wr_hi = 1'b0, i_wr_lo = 1'b0;
  logic [W-1:0]  i_wr_data = '0;
`ifdef MULDIV_FLUSH_EN
  logic          i_flush = 1'b0;
`endif
  logic          o_busy, o_done, o_div_by_zero;
  logic [W-1:0]  o_hi, o_lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_x           (i_x),
    .i_y           (i_y),
    .i_wr_hi       (i_wr_hi),
    .i_wr_lo       (i_wr_lo),
    .i_wr_data     (i_wr_data),
`ifdef MULDIV_FLUSH_EN
    .i_flush       (i_flush),
`endif
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero),
    .o_hi          (o_hi),
    .o_lo          (o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", what, obs, exp);
    end
  endtask

  // Present an operation for one edge, then drop start and any writes.
  task automatic launch(input string tag, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    i_op = op; i_x = x; i_y = y; i_start = 1'b1;
    step();
    i_start = 1'b0; i_wr_hi = 1'b0; i_wr_lo = 1'b0;
    chk({tag, " busy after start"}, 32'(o_busy), 32'd1);
  endtask

  // Wait (bounded) for done, checking latency and results. poke_at >= 0 drives
  // start and wr_hi during busy; both must be ignored.
  task automatic finish(input string tag, input int poke_at, input logic [31:0] hold_hi,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int n;
    n = 0;
    while (!o_done && n < 40) begin
      if (n == poke_at) begin
        i_start = 1'b1; i_wr_hi = 1'b1; i_wr_data = 32'h0000_00AA;
        i_op = 2'b11; i_x = 32'd9; i_y = 32'd4;
      end
      step();
      n++;
      i_start = 1'b0; i_wr_hi = 1'b0;
      if (poke_at >= 0 && n == poke_at + 1)
        chk({tag, " hi while busy"}, o_hi, hold_hi);
    end
    chk({tag, " latency"}, 32'(n), 32'd33);
    chk({tag, " done"}, 32'(o_done), 32'd1);
    chk({tag, " busy at done"}, 32'(o_busy), 32'd0);
    chk({tag, " hi"}, o_hi, ehi);
    chk({tag, " lo"}, o_lo, elo);
    chk({tag, " dbz"}, 32'(o_div_by_zero), 32'(edbz));
    step();
    chk({tag, " done falls"}, 32'(o_done), 32'd0);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int c;
    c = 0;
    repeat (cycles) begin
      step();
      if (o_done) c++;
    end
    chk({tag, " no done"}, 32'(c), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst hi", o_hi, 32'h0);
    chk("rst lo", o_lo, 32'h0);
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst dbz", 32'(o_div_by_zero), 32'd0);
    i_rst = 1'b0;
    step();

    // Multiplies
    launch("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish("multu max", -1, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    launch("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7);
    finish("mult -3*7", -1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    launch("mult minneg^2", 2'b00, 32'h8000_0000, 32'h8000_0000);
    finish("mult minneg^2", -1, 32'h0, 32'h4000_0000, 32'h0000_0000, 1'b0);

    // Divides
    launch("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    finish("div -7/2", -1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    launch("divu 7/2", 2'b11, 32'd7, 32'd2);
    finish("divu 7/2", -1, 32'h0, 32'd1, 32'd3, 1'b0);
    launch("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    finish("div ovf", -1, 32'h0, 32'h0, 32'h8000_0000, 1'b0);
    launch("divu by 0", 2'b11, 32'h0000_1234, 32'h0);
    finish("divu by 0", -1, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);

    // start and wr_hi during busy are dropped; exactly one done
    launch("busy poke", 2'b01, 32'd2, 32'd3);
    finish("busy poke", 5, 32'h0000_1234, 32'h0, 32'd6, 1'b0);
    no_done("busy poke", 40);

    // MTLO in idle lands at the next edge
    i_wr_lo = 1'b1; i_wr_data = 32'h0000_0055;
    step();
    i_wr_lo = 1'b0;
    chk("mtlo lo", o_lo, 32'h0000_0055);
    chk("mtlo hi kept", o_hi, 32'h0);

    // start coinciding with MTHI: write lands, result overwrites it later
    i_wr_hi = 1'b1; i_wr_data = 32'h0000_0077;
    launch("start+mthi", 2'b01, 32'd1, 32'd1);
    chk("start+mthi hi", o_hi, 32'h0000_0077);
    finish("start+mthi", -1, 32'h0, 32'h0, 32'd1, 1'b0);

    // Asynchronous reset mid-operation
    i_wr_hi = 1'b1; i_wr_data = 32'h0000_0012;
    step();
    i_wr_hi = 1'b0;
    launch("rst mid", 2'b00, 32'd3, 32'd7);
    repeat (9) step();
    #2 i_rst = 1'b1;
    #1;
    chk("rst mid busy", 32'(o_busy), 32'd0);
    chk("rst mid hi", o_hi, 32'h0);
    chk("rst mid lo", o_lo, 32'h0);
    chk("rst mid done", 32'(o_done), 32'd0);
    step();
    i_rst = 1'b0;
    no_done("rst mid", 40);
    chk("rst mid hi after", o_hi, 32'h0);

`ifdef MULDIV_FLUSH_EN
    // Flush: abort keeps HI/LO, no done, a following start completes normally
    i_wr_hi = 1'b1; i_wr_data = 32'd1;
    step();
    i_wr_hi = 1'b0; i_wr_lo = 1'b1; i_wr_data = 32'd2;
    step();
    i_wr_lo = 1'b0;
    launch("flush", 2'b11, 32'd100, 32'd7);
    repeat (9) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush busy", 32'(o_busy), 32'd0);
    chk("flush done", 32'(o_done), 32'd0);
    chk("flush hi", o_hi, 32'd1);
    chk("flush lo", o_lo, 32'd2);
    launch("after flush", 2'b11, 32'd100, 32'd7);
    finish("after flush", -1, 32'h0, 32'd2, 32'd14, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
